// File: rtl/game_io_pkg.sv
// Shared constants for the game I/O controller: register map, STATUS/CTRL bit
// positions and the CPU data width.
package game_io_pkg;

    localparam int DATA_W = 8;

    localparam logic [7:0] ADDR_LEDX    = 8'h00;
    localparam logic [7:0] ADDR_LEDY    = 8'h01;
    localparam logic [7:0] ADDR_STATUS  = 8'h02;
    localparam logic [7:0] ADDR_CTRL    = 8'h03;
    localparam logic [7:0] ADDR_TICKCNT = 8'h04;

    localparam int ST_BC   = 0;
    localparam int ST_BAC  = 1;
    localparam int ST_TICK = 2;

    localparam int CTRL_RUN    = 0;
    localparam int CTRL_COMMIT = 1;

endpackage

// File: rtl/game_io_ctrl_if.sv
// CPU I/O bus between the processor (master) and the game I/O controller (slave).
interface game_io_ctrl_if;
    import game_io_pkg::*;

    logic              io_en;
    logic              io_we;
    logic              io_re;
    logic [7:0]        addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rdata_oe;

    modport master (output io_en, io_we, io_re, addr, wdata, input rdata, rdata_oe);
    modport slave  (input io_en, io_we, io_re, addr, wdata, output rdata, rdata_oe);

endinterface

// File: rtl/game_io_ctrl_btn_cond.sv
// Button conditioner: 2-flop synchronizer, optional debounce (GAME_IO_DEBOUNCE_EN),
// and a one-cycle pulse on each rising edge of the accepted level.
module btn_cond #(
    parameter logic [7:0] DB_CYCLES = 8'd16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic rise_o
);

    logic [1:0] sync_q;
    logic       prev_q;
    logic       level_s;

    // Metastability guard for the asynchronous button input
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn_i};
        end
    end

`ifdef GAME_IO_DEBOUNCE_EN
    logic       db_q;
    logic [7:0] db_cnt_q;

    // Count consecutive samples that disagree with the accepted level
    always_ff @(posedge clk) begin
        if (reset) begin
            db_q     <= 1'b0;
            db_cnt_q <= 8'd0;
        end else if (sync_q[1] == db_q) begin
            db_cnt_q <= 8'd0;
        end else if (db_cnt_q == DB_CYCLES - 8'd1) begin
            db_q     <= sync_q[1];
            db_cnt_q <= 8'd0;
        end else begin
            db_cnt_q <= db_cnt_q + 8'd1;
        end
    end

    assign level_s = db_q;
`else
    assign level_s = sync_q[1];
`endif

    // Previous accepted level for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level_s;
        end
    end

    assign rise_o = level_s & ~prev_q;

endmodule

// File: rtl/game_io_ctrl.sv
// Game I/O controller: CPU register file, sticky button events, game tick timer
// and double-buffered LED outputs. Debounce enabled by GAME_IO_DEBOUNCE_EN.
module game_io_ctrl
    import game_io_pkg::*;
#(
    parameter logic [15:0] TICK_DIV  = 16'd50000,
    parameter logic [7:0]  DB_CYCLES = 8'd16
) (
    input  logic              clk,
    input  logic              reset,
    game_io_ctrl_if.slave     bus,
    input  logic              bc,
    input  logic              bac,
    output logic [DATA_W-1:0] led_x,
    output logic [DATA_W-1:0] led_y,
    output logic              tick
);

    localparam logic [15:0] TICK_MAX = TICK_DIV - 16'd1;

    logic              bc_rise_s, bac_rise_s;
    logic              wr_s, rd_s, commit_s, clr_s;
    logic [2:0]        set_s;
    logic [DATA_W-1:0] rd_mux_s;

    logic [DATA_W-1:0] stage_x_q, stage_x_d, stage_y_q, stage_y_d;
    logic [DATA_W-1:0] led_x_q, led_x_d, led_y_q, led_y_d;
    logic              run_q, run_d;
    logic [2:0]        flags_q, flags_d;
    logic [7:0]        tickcnt_q, tickcnt_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              tick_q, tick_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              oe_q, oe_d;

    btn_cond #(.DB_CYCLES(DB_CYCLES)) u_bc  (.clk(clk), .reset(reset), .btn_i(bc),  .rise_o(bc_rise_s));
    btn_cond #(.DB_CYCLES(DB_CYCLES)) u_bac (.clk(clk), .reset(reset), .btn_i(bac), .rise_o(bac_rise_s));

    // Read data selection from pre-edge register state
    always_comb begin
        rd_mux_s = 8'h00;
        case (bus.addr)
            ADDR_LEDX:    rd_mux_s = stage_x_q;
            ADDR_LEDY:    rd_mux_s = stage_y_q;
            ADDR_STATUS:  rd_mux_s = {5'b00000, flags_q};
            ADDR_CTRL:    rd_mux_s = {6'b000000, 1'b0, run_q};
            ADDR_TICKCNT: rd_mux_s = tickcnt_q;
            default:      rd_mux_s = 8'h00;
        endcase
    end

    // Next-state logic; tick_q mirrors "run and counter at its last value",
    // so it doubles as the wrap condition for this edge.
    always_comb begin
        wr_s      = bus.io_en & bus.io_we;
        rd_s      = bus.io_en & bus.io_re;
        stage_x_d = stage_x_q;
        stage_y_d = stage_y_q;
        run_d     = run_q;
        commit_s  = 1'b0;
        if (wr_s) begin
            case (bus.addr)
                ADDR_LEDX: stage_x_d = bus.wdata;
                ADDR_LEDY: stage_y_d = bus.wdata;
                ADDR_CTRL: begin
                    run_d    = bus.wdata[CTRL_RUN];
                    commit_s = bus.wdata[CTRL_COMMIT];
                end
                default:   commit_s = 1'b0;
            endcase
        end else begin
            commit_s = 1'b0;
        end

        if (run_q) begin
            cnt_d = tick_q ? 16'd0 : cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
        tick_d = run_d && (cnt_d == TICK_MAX);

        set_s          = 3'b000;
        set_s[ST_BC]   = bc_rise_s;
        set_s[ST_BAC]  = bac_rise_s;
        set_s[ST_TICK] = tick_q;
        clr_s          = rd_s && (bus.addr == ADDR_STATUS);
        flags_d        = (clr_s ? 3'b000 : flags_q) | set_s;
        tickcnt_d      = tickcnt_q + {7'd0, tick_q};

        if (tick_q || commit_s) begin
            led_x_d = stage_x_d;
            led_y_d = stage_y_d;
        end else begin
            led_x_d = led_x_q;
            led_y_d = led_y_q;
        end

        rdata_d = rd_s ? rd_mux_s : 8'h00;
        oe_d    = rd_s;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_x_q <= 8'h00;
            stage_y_q <= 8'h00;
            led_x_q   <= 8'h00;
            led_y_q   <= 8'h00;
            run_q     <= 1'b0;
            flags_q   <= 3'b000;
            tickcnt_q <= 8'h00;
            cnt_q     <= 16'd0;
            tick_q    <= 1'b0;
            rdata_q   <= 8'h00;
            oe_q      <= 1'b0;
        end else begin
            stage_x_q <= stage_x_d;
            stage_y_q <= stage_y_d;
            led_x_q   <= led_x_d;
            led_y_q   <= led_y_d;
            run_q     <= run_d;
            flags_q   <= flags_d;
            tickcnt_q <= tickcnt_d;
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
            rdata_q   <= rdata_d;
            oe_q      <= oe_d;
        end
    end

    assign led_x        = led_x_q;
    assign led_y        = led_y_q;
    assign tick         = tick_q;
    assign bus.rdata    = rdata_q;
    assign bus.rdata_oe = oe_q;

endmodule

// File: tb/tb_game_io_ctrl.sv
// Self-checking bench for game_io_ctrl: behavioural model compared every cycle,
// directed literal checks, then randomized bus/button/reset traffic.
module tb_game_io_ctrl;

    localparam int TD = 4;
    localparam int DB = 16;
`ifdef GAME_IO_DEBOUNCE_EN
    localparam int EVT_DLY = 18;
    localparam logic [7:0] GLITCH_EXP = 8'h00;
`else
    localparam int EVT_DLY = 2;
    localparam logic [7:0] GLITCH_EXP = 8'h01;
`endif

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       bc    = 1'b0;
    logic       bac   = 1'b0;
    logic [7:0] led_x, led_y;
    logic       tick;
    int         tests = 0;
    int         fails = 0;

    game_io_ctrl_if bus();

    game_io_ctrl #(.TICK_DIV(16'd4), .DB_CYCLES(8'd16)) dut (
        .clk(clk), .reset(reset), .bus(bus), .bc(bc), .bac(bac),
        .led_x(led_x), .led_y(led_y), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_sx = 8'h00, m_sy = 8'h00, m_lx = 8'h00, m_ly = 8'h00;
    logic [7:0] m_tc = 8'h00, m_rd = 8'h00;
    logic [2:0] m_flags = 3'b000;
    bit         m_run = 1'b0, m_oe = 1'b0;
    int         m_runs = 0;            // running cycles elapsed since reset
    bit         hist [0:1][0:2];       // [btn][k]: raw sample taken k+1 edges ago
    bit         evt [0:1];
    int         runlen [0:1];
    bit         lastv [0:1], acc [0:1], accp [0:1];

    function automatic bit exp_tick();
        return m_run && ((m_runs % TD) == TD - 1);
    endfunction

    function automatic logic [7:0] m_read(input logic [7:0] a);
        case (a)
            8'h00:   return m_sx;
            8'h01:   return m_sy;
            8'h02:   return {5'b0, m_flags};
            8'h03:   return {7'b0, m_run};
            8'h04:   return m_tc;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        bit tnow, wr, rdv, commit;
        bit raw [0:1];
        raw[0] = bc;
        raw[1] = bac;
        if (reset) begin
            m_sx = 8'h00; m_sy = 8'h00; m_lx = 8'h00; m_ly = 8'h00;
            m_tc = 8'h00; m_rd = 8'h00; m_flags = 3'b000;
            m_run = 1'b0; m_oe = 1'b0; m_runs = 0;
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < 3; k++) hist[b][k] = 1'b0;
                runlen[b] = 0; lastv[b] = 1'b0; acc[b] = 1'b0; accp[b] = 1'b0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
`ifdef GAME_IO_DEBOUNCE_EN
                evt[b]  = acc[b] & ~accp[b];
                accp[b] = acc[b];
                if (hist[b][1] == lastv[b]) runlen[b]++;
                else begin lastv[b] = hist[b][1]; runlen[b] = 1; end
                if (runlen[b] >= DB && lastv[b] != acc[b]) acc[b] = lastv[b];
`else
                evt[b] = hist[b][1] & ~hist[b][2];
`endif
                hist[b][2] = hist[b][1];
                hist[b][1] = hist[b][0];
                hist[b][0] = raw[b];
            end
            tnow = exp_tick();
            wr   = bus.io_en & bus.io_we;
            rdv  = bus.io_en & bus.io_re;
            m_rd = rdv ? m_read(bus.addr) : 8'h00;
            m_oe = rdv;
            if (rdv && bus.addr == 8'h02) m_flags = 3'b000;
            m_flags = m_flags | {tnow, evt[1], evt[0]};
            if (tnow) m_tc = m_tc + 8'd1;
            if (m_run) m_runs++;
            commit = 1'b0;
            if (wr) begin
                if (bus.addr == 8'h00) m_sx = bus.wdata;
                if (bus.addr == 8'h01) m_sy = bus.wdata;
                if (bus.addr == 8'h03) begin
                    m_run  = bus.wdata[0];
                    commit = bus.wdata[1];
                end
            end
            if (tnow || commit) begin
                m_lx = m_sx;
                m_ly = m_sy;
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        chk("led_x", {8'h00, led_x}, {8'h00, m_lx});
        chk("led_y", {8'h00, led_y}, {8'h00, m_ly});
        chk("tick_oe_rdata", {6'b0, tick, bus.rdata_oe, bus.rdata},
                             {6'b0, exp_tick(), m_oe, m_rd});
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic op(input logic we, input logic re, input logic [7:0] a,
                      input logic [7:0] d, output logic [7:0] rd);
        bus.io_en = 1'b1; bus.io_we = we; bus.io_re = re;
        bus.addr  = a;    bus.wdata = d;
        @(negedge clk);
        rd = bus.rdata;
        bus.io_en = 1'b0; bus.io_we = 1'b0; bus.io_re = 1'b0;
    endtask

    initial begin
        logic [7:0] r;
        int nt;
        bus.io_en = 1'b0; bus.io_we = 1'b0; bus.io_re = 1'b0;
        bus.addr = 8'h00; bus.wdata = 8'h00;
        idle(2);
        reset = 1'b0;
        chk("rst_led_x", {8'h00, led_x}, 16'h0000);
        chk("rst_oe", {15'h0, bus.rdata_oe}, 16'h0000);

        // stage + explicit commit, then read back
        op(1'b1, 1'b0, 8'h00, 8'hA5, r);
        op(1'b1, 1'b0, 8'h01, 8'h3C, r);
        op(1'b1, 1'b0, 8'h03, 8'h02, r);
        chk("commit_x", {8'h00, led_x}, 16'h00A5);
        chk("commit_y", {8'h00, led_y}, 16'h003C);
        op(1'b0, 1'b1, 8'h00, 8'h00, r);
        chk("rd_ledx", {8'h00, r}, 16'h00A5);
        chk("rd_oe_on", {15'h0, bus.rdata_oe}, 16'h0001);
        idle(1);
        chk("rd_oe_off", {15'h0, bus.rdata_oe}, 16'h0000);

        // tick-driven commit and TICKCNT
        op(1'b1, 1'b0, 8'h00, 8'h81, r);
        op(1'b1, 1'b0, 8'h03, 8'h01, r);
        nt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (tick) nt++;
            if (i == 3) chk("tick_led_x", {8'h00, led_x}, 16'h0081);
        end
        chk("tick_count", nt[15:0], 16'd3);
        op(1'b0, 1'b1, 8'h04, 8'h00, r);
        chk("tickcnt", {8'h00, r}, 16'h0003);
        op(1'b1, 1'b0, 8'h03, 8'h00, r);
        op(1'b0, 1'b1, 8'h02, 8'h00, r);
        chk("status_tick", {8'h00, r}, 16'h0004);

        // long press: flag, then read-clear
        bc = 1'b1; idle(40); bc = 1'b0; idle(25);
        op(1'b0, 1'b1, 8'h02, 8'h00, r);
        chk("status_bc", {8'h00, r}, 16'h0001);
        op(1'b0, 1'b1, 8'h02, 8'h00, r);
        chk("status_clr", {8'h00, r}, 16'h0000);

        // flag set collides with read-clear: event survives
        bac = 1'b1; idle(EVT_DLY);
        op(1'b0, 1'b1, 8'h02, 8'h00, r);
        chk("collide_rd1", {8'h00, r}, 16'h0000);
        op(1'b0, 1'b1, 8'h02, 8'h00, r);
        chk("collide_rd2", {8'h00, r}, 16'h0002);
        bac = 1'b0; idle(25);

        // short glitch
        bc = 1'b1; idle(5); bc = 1'b0; idle(25);
        op(1'b0, 1'b1, 8'h02, 8'h00, r);
        chk("glitch", {8'h00, r}, {8'h00, GLITCH_EXP});

        // reset during run with pending flags and a read in flight
        op(1'b1, 1'b0, 8'h00, 8'h5A, r);
        op(1'b1, 1'b0, 8'h03, 8'h03, r);
        bc = 1'b1; idle(20); bc = 1'b0; idle(3);
        bus.io_en = 1'b1; bus.io_re = 1'b1; bus.addr = 8'h02; reset = 1'b1;
        idle(1);
        chk("rst_mid_read_oe", {15'h0, bus.rdata_oe}, 16'h0000);
        bus.io_en = 1'b0; bus.io_re = 1'b0;
        idle(1);
        reset = 1'b0;
        chk("rst_run_led_x", {8'h00, led_x}, 16'h0000);
        chk("rst_run_led_y", {8'h00, led_y}, 16'h0000);
        nt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tick) nt++;
        end
        chk("rst_no_tick", nt[15:0], 16'd0);
        op(1'b0, 1'b1, 8'h02, 8'h00, r);
        chk("rst_status", {8'h00, r}, 16'h0000);
        op(1'b0, 1'b1, 8'h04, 8'h00, r);
        chk("rst_tickcnt", {8'h00, r}, 16'h0000);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            bus.io_en = ($urandom_range(0, 3) != 0);
            bus.io_we = 1'($urandom_range(0, 1));
            bus.io_re = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) bus.addr = 8'($urandom);
            else bus.addr = 8'($urandom_range(0, 4));
            bus.wdata = 8'($urandom);
            if ($urandom_range(0, 15) == 0) bc = ~bc;
            if ($urandom_range(0, 15) == 0) bac = ~bac;
            reset = ($urandom_range(0, 499) == 0);
            @(negedge clk);
        end
        bus.io_en = 1'b0; bus.io_we = 1'b0; bus.io_re = 1'b0;
        reset = 1'b0;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
